display_fetch_arbiter: RTL and testbench

DISPLAY_FETCH_ARBITER -- requirements
Module: display_fetch_arbiter

---
 rtl/display_fetch_arbiter.sv | 90 +++++++++
 tb/tb_display_fetch_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/display_fetch_arbiter.sv
// display_fetch_arbiter: 3-way burst arbiter (pixel fetch first, units 0/1 round-robin) for one memory port.
// Defining ARB_MAX_WAIT_EN adds the max_wait output tracking the longest requester wait.
module display_fetch_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [21:0] req0_address,
  input  logic        req0_as,
  output logic        req0_ack,
  output logic        req0_burstdata_valid,
  input  logic [21:0] req1_address,
  input  logic        req1_as,
  output logic        req1_ack,
  output logic        req1_burstdata_valid,
  input  logic [21:0] req2_address,
  input  logic        req2_as,
  output logic        req2_ack,
  output logic        req2_burstdata_valid,
  output logic [21:0] mem_address,
  output logic        mem_as,
  input  logic        mem_ack,
  input  logic        mem_burstdata_valid,
  output logic [1:0]  grant
`ifdef ARB_MAX_WAIT_EN
  , output logic [7:0] max_wait
`endif
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      r_state;
  logic        r_mem_as;
  logic        r_last;
  logic [1:0]  r_grant;
  logic [21:0] r_mem_address;
  logic [2:0]  w_as;
  logic [1:0]  w_win;
  logic [21:0] w_addr;
  logic        w_busy;
  assign w_as   = {req2_as, req1_as, req0_as};
  assign w_busy = r_state == BUSY;
  // r_last holds the unit served last, so the other one wins a 0/1 tie
  assign w_win  = req2_as ? 2'd2 : (req0_as && (!req1_as || r_last)) ? 2'd0 : 2'd1;
  assign w_addr = w_win == 2'd2 ? req2_address : w_win == 2'd1 ? req1_address : req0_address;
  assign mem_as      = r_mem_as;
  assign mem_address = r_mem_address;
  assign grant       = r_grant;
  assign req0_ack = w_busy && r_grant == 2'd0 && mem_ack;
  assign req1_ack = w_busy && r_grant == 2'd1 && mem_ack;
  assign req2_ack = w_busy && r_grant == 2'd2 && mem_ack;
  assign req0_burstdata_valid = w_busy && r_grant == 2'd0 && mem_burstdata_valid;
  assign req1_burstdata_valid = w_busy && r_grant == 2'd1 && mem_burstdata_valid;
  assign req2_burstdata_valid = w_busy && r_grant == 2'd2 && mem_burstdata_valid;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_mem_as      <= 1'b0;
      r_mem_address <= '0;
      r_grant       <= 2'd3;
      r_last        <= 1'b1;
    end else if (r_state == IDLE) begin
      if (|w_as) begin
        r_state       <= BUSY;
        r_mem_as      <= 1'b1;
        r_grant       <= w_win;
        r_mem_address <= w_addr;
        if (!w_win[1]) r_last <= w_win[0];
      end
    end else if (mem_ack) begin
      r_state  <= IDLE;
      r_mem_as <= 1'b0;
      r_grant  <= 2'd3;
    end
  end
`ifdef ARB_MAX_WAIT_EN
  logic [7:0] r_wait [3];
  logic [7:0] r_max;
  logic [7:0] w_max;
  logic       w_take;
  assign w_take   = r_state == IDLE && |w_as;
  assign max_wait = r_max;
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      if (reset || (w_take && w_win == 2'(i))) r_wait[i] <= '0;
      else if (w_as[i] && !(w_busy && r_grant == 2'(i)) && r_wait[i] != 8'hff) r_wait[i] <= r_wait[i] + 8'd1;
    r_max <= reset ? 8'd0 : w_max;
  end
  always_comb begin
    w_max = r_max;
    for (int i = 0; i < 3; i++) w_max = r_wait[i] > w_max ? r_wait[i] : w_max;
  end
`endif
endmodule

// File: tb/tb_display_fetch_arbiter.sv
// tb_display_fetch_arbiter: directed bursts; expected {grant,address} queued per burst, checked by a monitor.
module tb_display_fetch_arbiter;
  logic        clk = 0;
  logic        reset = 1;
  logic [21:0] addr [3];
  logic        as_ [3];
  logic        mem_ack = 0, mem_bdv = 0;
  logic [21:0] mem_address;
  logic        mem_as;
  logic [1:0]  grant;
  logic [2:0]  acks, bdvs;
`ifdef ARB_MAX_WAIT_EN
  logic [7:0]  max_wait;
`endif
  int          n_tests = 0, n_fail = 0;
  logic [23:0] q [$];
  logic        prev_as = 0;

  display_fetch_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_address(addr[0]), .req0_as(as_[0]), .req0_ack(acks[0]), .req0_burstdata_valid(bdvs[0]),
    .req1_address(addr[1]), .req1_as(as_[1]), .req1_ack(acks[1]), .req1_burstdata_valid(bdvs[1]),
    .req2_address(addr[2]), .req2_as(as_[2]), .req2_ack(acks[2]), .req2_burstdata_valid(bdvs[2]),
    .mem_address(mem_address), .mem_as(mem_as), .mem_ack(mem_ack),
    .mem_burstdata_valid(mem_bdv), .grant(grant)
`ifdef ARB_MAX_WAIT_EN
    , .max_wait(max_wait)
`endif
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (mem_as && !prev_as) begin
      if (q.size() == 0) chk("unexpected_burst", 1, 0);
      else begin
        logic [23:0] e;
        e = q.pop_front();
        chk("mon_grant", int'(grant), int'(e[23:22]));
        chk("mon_addr", int'(mem_address), int'(e[21:0]));
      end
    end
    prev_as = mem_as;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    for (int i = 0; i < 3; i++) as_[i] = 0;
    mem_ack = 0;
    mem_bdv = 0;
    tick();
    tick();
    reset = 0;
  endtask

  // serve one burst for requester g: dly cycles after mem_as, alternating data strobes, then ack
  task automatic burst(input int g, input int dly, input bit rearm, input logic [21:0] naddr, input int exp_wait);
    int t = 0;
    while (!mem_as && t < 50) begin tick(); t++; end
    chk("burst_start", int'(mem_as), 1);
    if (exp_wait >= 0) chk("burst_gap", t, exp_wait);
    for (int i = 0; i < dly - 1; i++) begin
      mem_bdv = i[0];
      #1;
      chk("bdv_route", int'(bdvs), i[0] ? (1 << g) : 0);
      chk("no_early_ack", int'(acks), 0);
      tick();
    end
    mem_bdv = 0;
    mem_ack = 1;
    if (rearm) addr[g] = naddr;
    else as_[g] = 0;
    #1;
    chk("ack_route", int'(acks), 1 << g);
    tick();
    mem_ack = 0;
    #1;
    chk("idle_mem_as", int'(mem_as), 0);
    chk("idle_grant", int'(grant), 3);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin addr[i] = '0; as_[i] = 0; end
    tick();
    tick();
    chk("rst_grant", int'(grant), 3);
    chk("rst_mem_as", int'(mem_as), 0);
    chk("rst_mem_addr", int'(mem_address), 0);
    chk("rst_acks", int'(acks), 0);
    chk("rst_bdvs", int'(bdvs), 0);
    reset = 0;
    tick();
    // single req0 burst
    addr[0] = 22'h000400;
    as_[0] = 1;
    q.push_back({2'd0, 22'h000400});
    #1;
    chk("idle_before_grant", int'(mem_as), 0);
    tick();
    chk("single_mem_as", int'(mem_as), 1);
    chk("single_grant", int'(grant), 0);
    burst(0, 6, 0, '0, 0);
    // idle memory strobes are ignored
    mem_ack = 1;
    mem_bdv = 1;
    #1;
    chk("idle_ack_drop", int'(acks), 0);
    chk("idle_bdv_drop", int'(bdvs), 0);
    tick();
    mem_ack = 0;
    mem_bdv = 0;
    chk("idle_stays", int'(mem_as), 0);
    // req0/req1 contend from reset: strict alternation
    do_reset();
    addr[0] = 22'h000100;
    addr[1] = 22'h000200;
    as_[0] = 1;
    as_[1] = 1;
    for (int k = 0; k < 4; k++) begin
      q.push_back({2'd0, 22'h000100});
      q.push_back({2'd1, 22'h000200});
    end
    for (int k = 0; k < 4; k++) begin
      burst(0, 3, k < 3, 22'h000100, k == 0 ? -1 : 1);
      burst(1, 3, k < 3, 22'h000200, 1);
    end
    // req2 beats waiting req1; req0 dropping as mid-burst does not abort it
    do_reset();
    addr[0] = 22'h000300;
    as_[0] = 1;
    q.push_back({2'd0, 22'h000300});
    tick();
    as_[0] = 0;
    addr[1] = 22'h000310;
    as_[1] = 1;
    tick();
    addr[2] = 22'h000320;
    as_[2] = 1;
    addr[0] = 22'h3fffff;
    q.push_back({2'd2, 22'h000320});
    q.push_back({2'd1, 22'h000310});
    #1;
    chk("busy_addr_hold", int'(mem_address), 22'h000300);
    chk("busy_grant_hold", int'(grant), 0);
    burst(0, 4, 0, '0, 0);
    burst(2, 2, 0, '0, 1);
    burst(1, 9, 0, '0, 1);
    // req1 back-to-back with new address
    do_reset();
    addr[1] = 22'h001000;
    as_[1] = 1;
    q.push_back({2'd1, 22'h001000});
    q.push_back({2'd1, 22'h001008});
    burst(1, 2, 1, 22'h001008, -1);
    burst(1, 2, 0, '0, 1);
    // reset mid-burst discards it
    do_reset();
    addr[0] = 22'h000500;
    as_[0] = 1;
    q.push_back({2'd0, 22'h000500});
    tick();
    tick();
    tick();
    reset = 1;
    as_[0] = 0;
    tick();
    reset = 0;
    chk("rst_busy_as", int'(mem_as), 0);
    chk("rst_busy_grant", int'(grant), 3);
    mem_ack = 1;
    #1;
    chk("rst_busy_noack", int'(acks), 0);
    tick();
    mem_ack = 0;
`ifdef ARB_MAX_WAIT_EN
    do_reset();
    chk("mw_reset", int'(max_wait), 0);
    addr[0] = 22'h000600;
    addr[1] = 22'h000700;
    as_[0] = 1;
    q.push_back({2'd0, 22'h000600});
    q.push_back({2'd1, 22'h000700});
    tick();
    as_[1] = 1;
    repeat (300) tick();
    chk("mw_saturate", int'(max_wait), 255);
    burst(0, 1, 0, '0, 0);
    burst(1, 1, 0, '0, 1);
`endif
    tick();
    tick();
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
